// File: rtl/alu_response_checker.sv
// Response checker for the 16-bit ALU: recomputes the golden result, counts transactions/mismatches,
// logs mismatch records in a FIFO. Define ALU_CHK_FLAGS_EN to include the flag vector in the comparison.
module alu_response_checker #(
  parameter int WIDTH       = 16,
  parameter int LOG_DEPTH   = 4,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic                 Cin,
  input  logic [3:0]           opcode,
  input  logic [WIDTH-1:0]     out,
  input  logic                 Cout,
  input  logic                 lt,
  input  logic                 eq,
  input  logic                 gt,
  input  logic                 V,
  output logic [15:0]          txn_count,
  output logic [15:0]          err_count,
  output logic                 err,
  output logic                 log_overflow,
  output logic                 log_valid,
  input  logic                 log_ready,
  output logic [4*WIDTH+13:0]  log_data
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int RW = 4*WIDTH + 14;

  typedef enum logic {RUN, HALT} state_t;
  state_t state;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x, s1_y, s1_out;
  logic             s1_cin;
  logic [3:0]       s1_op;
  logic [4:0]       s1_flags;

  logic [WIDTH:0]   sum_add, sum_sub;
  logic [WIDTH-1:0] exp_out;
  logic [4:0]       exp_flags;
  logic             exp_c, exp_v, slt, supported, mismatch;
  logic [RW-1:0]    rec;

  logic [RW-1:0]    mem [LOG_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      cnt;
  logic             full, push, pop, push_ok;

  always_comb begin
    sum_add   = {1'b0, s1_x} + {1'b0, s1_y} + {{WIDTH{1'b0}}, s1_cin};
    sum_sub   = {1'b0, s1_x} + {1'b0, ~s1_y} + {{WIDTH{1'b0}}, 1'b1};
    slt       = $signed(s1_x) < $signed(s1_y);
    exp_out   = '0;
    exp_c     = 1'b0;
    exp_v     = 1'b0;
    supported = 1'b1;
    case (s1_op)
      4'b0010: begin
        exp_out = sum_add[WIDTH-1:0];
        exp_c   = sum_add[WIDTH];
        exp_v   = (s1_x[WIDTH-1] == s1_y[WIDTH-1]) && (sum_add[WIDTH-1] != s1_x[WIDTH-1]);
      end
      4'b0110: begin
        exp_out = sum_sub[WIDTH-1:0];
        exp_c   = sum_sub[WIDTH];
        exp_v   = (s1_x[WIDTH-1] != s1_y[WIDTH-1]) && (sum_sub[WIDTH-1] != s1_x[WIDTH-1]);
      end
      4'b0000: exp_out = s1_x & s1_y;
      4'b0001: exp_out = s1_x | s1_y;
      4'b1100: exp_out = ~(s1_x | s1_y);
      4'b0111: exp_out = {{(WIDTH-1){1'b0}}, slt};
      default: supported = 1'b0;
    endcase
    exp_flags = {exp_c, slt, s1_x == s1_y, !slt && (s1_x != s1_y), exp_v};
`ifdef ALU_CHK_FLAGS_EN
    mismatch = s1_valid && supported && ((s1_out != exp_out) || (s1_flags != exp_flags));
`else
    mismatch = s1_valid && supported && (s1_out != exp_out);
`endif
    rec = {s1_op, s1_x, s1_y, s1_out, exp_out, s1_flags, exp_flags};
  end

  // A full log still accepts a push when the head is popped on the same edge.
  assign full      = (cnt == LOG_DEPTH[PW:0]);
  assign log_valid = (cnt != '0);
  assign pop       = log_valid && log_ready;
  assign push      = mismatch && !rst;
  assign push_ok   = push && (!full || pop);
  assign log_data  = log_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      in_ready     <= 1'b1;
      s1_valid     <= 1'b0;
      s1_x         <= '0;
      s1_y         <= '0;
      s1_out       <= '0;
      s1_cin       <= 1'b0;
      s1_op        <= '0;
      s1_flags     <= '0;
      txn_count    <= '0;
      err_count    <= '0;
      err          <= 1'b0;
      log_overflow <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
    end else begin
      s1_valid <= in_valid && in_ready;
      if (in_valid && in_ready) begin
        s1_x     <= X;
        s1_y     <= Y;
        s1_cin   <= Cin;
        s1_op    <= opcode;
        s1_out   <= out;
        s1_flags <= {Cout, lt, eq, gt, V};
      end

      if (s1_valid && (txn_count != '1)) txn_count <= txn_count + 16'd1;
      if (mismatch) begin
        err <= 1'b1;
        if (err_count != '1) err_count <= err_count + 16'd1;
      end

      case (state)
        RUN: begin
          in_ready <= 1'b1;
          if (mismatch && (STOP_ON_ERR != 0)) begin
            state    <= HALT;
            in_ready <= 1'b0;
          end
        end
        HALT: in_ready <= 1'b0;
        default: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
      endcase

      if (push && !push_ok) log_overflow <= 1'b1;
      if (push_ok) wr_ptr <= (wr_ptr == PW'(LOG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)     rd_ptr <= (rd_ptr == PW'(LOG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (push_ok && !pop)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_response_checker.sv
// Directed scoreboard bench for alu_response_checker; a second instance exercises STOP_ON_ERR=1.
module tb_alu_response_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] X = '0, Y = '0, out = '0;
  logic        Cin = 1'b0;
  logic [3:0]  opcode = '0;
  logic [4:0]  flags = '0;
  logic        Cout, lt, eq, gt, V;
  logic        log_ready = 1'b0;

  logic        in_ready, err, log_overflow, log_valid;
  logic [15:0] txn_count, err_count;
  logic [77:0] log_data;

  logic        in_ready2, err2, log_overflow2, log_valid2;
  logic [15:0] txn_count2, err_count2;
  logic [77:0] log_data2;

  assign {Cout, lt, eq, gt, V} = flags;

  always #5 clk = ~clk;

  alu_response_checker #(.WIDTH(16), .LOG_DEPTH(4), .STOP_ON_ERR(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .Cin(Cin), .opcode(opcode), .out(out),
    .Cout(Cout), .lt(lt), .eq(eq), .gt(gt), .V(V),
    .txn_count(txn_count), .err_count(err_count), .err(err),
    .log_overflow(log_overflow), .log_valid(log_valid),
    .log_ready(log_ready), .log_data(log_data)
  );

  alu_response_checker #(.WIDTH(16), .LOG_DEPTH(4), .STOP_ON_ERR(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .X(X), .Y(Y), .Cin(Cin), .opcode(opcode), .out(out),
    .Cout(Cout), .lt(lt), .eq(eq), .gt(gt), .V(V),
    .txn_count(txn_count2), .err_count(err_count2), .err(err2),
    .log_overflow(log_overflow2), .log_valid(log_valid2),
    .log_ready(1'b0), .log_data(log_data2)
  );

  int          nassert = 0;
  int          nfail   = 0;
  int unsigned mtxn, merr;
  logic        merr_flag, movf;
  logic [77:0] q[$];

  // Returns {supported, expected out, expected {Cout,lt,eq,gt,V}}.
  function automatic logic [21:0] golden(input logic [15:0] x, input logic [15:0] y,
                                         input logic cin, input logic [3:0] op);
    int          sx, sy, r;
    int unsigned ux, uy;
    logic [15:0] eo;
    logic        c, v, ok, l, e, g;
    sx = $signed(x);
    sy = $signed(y);
    ux = {16'b0, x};
    uy = {16'b0, y};
    l = sx < sy;
    e = sx == sy;
    g = sx > sy;
    c = 1'b0;
    v = 1'b0;
    ok = 1'b1;
    eo = '0;
    case (op)
      4'h2: begin
        r  = sx + sy + int'(cin);
        eo = 16'(ux + uy + {31'b0, cin});
        c  = (ux + uy + {31'b0, cin}) > 32'd65535;
        v  = (r > 32767) || (r < -32768);
      end
      4'h6: begin
        r  = sx - sy;
        eo = 16'(ux - uy);
        c  = ux >= uy;
        v  = (r > 32767) || (r < -32768);
      end
      4'h0: eo = x & y;
      4'h1: eo = x | y;
      4'hC: eo = ~(x | y);
      4'h7: eo = {15'b0, l};
      default: ok = 1'b0;
    endcase
    return {ok, eo, c, l, e, g, v};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mtxn = 0;
    merr = 0;
    merr_flag = 1'b0;
    movf = 1'b0;
    q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic cin,
                      input logic [3:0] op, input logic [15:0] got, input logic [4:0] gf);
    logic [21:0] g;
    logic        bad;
    g = golden(x, y, cin, op);
`ifdef ALU_CHK_FLAGS_EN
    bad = g[21] && ((got != g[20:5]) || (gf != g[4:0]));
`else
    bad = g[21] && (got != g[20:5]);
`endif
    mtxn++;
    if (bad) begin
      merr++;
      merr_flag = 1'b1;
      if (q.size() < 4) q.push_back({op, x, y, got, g[20:5], gf, g[4:0]});
      else movf = 1'b1;
    end
    X = x; Y = y; Cin = cin; opcode = op; out = got; flags = gf;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic flush();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".txn_count"}, txn_count, mtxn[15:0]);
    chk({tag, ".err_count"}, err_count, merr[15:0]);
    chk({tag, ".err"}, err, merr_flag);
    chk({tag, ".log_valid"}, log_valid, q.size() != 0);
    chk({tag, ".log_overflow"}, log_overflow, movf);
  endtask

  task automatic pop_chk(input string tag);
    logic [77:0] e;
    e = q.pop_front();
    chk({tag, ".pop_valid"}, log_valid, 1'b1);
    chk({tag, ".pop_data"}, log_data, e);
    log_ready = 1'b1;
    @(posedge clk);
    #1 log_ready = 1'b0;
  endtask

  initial begin
    logic [3:0]  ops [6];
    logic [21:0] g;
    logic [15:0] rx, ry;
    logic [77:0] head;
    ops = '{4'h2, 4'h6, 4'h0, 4'h1, 4'hC, 4'h7};

    do_reset();
    chk("rst.in_ready", in_ready, 1'b1);
    chk("rst.in_ready2", in_ready2, 1'b1);
    chk("rst.log_data", log_data, 78'd0);
    chk_state("rst");

    send(16'h0005, 16'h0005, 1'b0, 4'b0010, 16'h000A, 5'b00100);
    flush();
    chk("add.txn_one", txn_count, 16'd1);
    chk_state("add");

    send(16'h0003, 16'h0008, 1'b0, 4'b0110, 16'hFFFB, 5'b01000);
    send(16'h0003, 16'h0008, 1'b0, 4'b0110, 16'hFFFA, 5'b01000);
    flush();
    chk_state("sub");
    chk("sub.exp_out", log_data[25:10], 16'hFFFB);
    chk("sub.got_out", log_data[41:26], 16'hFFFA);
    pop_chk("sub");

    send(16'h0007, 16'h0006, 1'b0, 4'b0000, 16'h0006, 5'b00010);
    send(16'h0007, 16'h0006, 1'b0, 4'b0000, 16'h0006, 5'b10010);
    flush();
    chk_state("and");
    while (q.size() != 0) pop_chk("and");

    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      ry = (i == 5) ? rx : 16'($urandom);
      g  = golden(rx, ry, 1'(i), ops[i % 6]);
      send(rx, ry, 1'(i), ops[i % 6], g[20:5] ^ ((i % 3 == 0) ? 16'h0100 : 16'h0000), g[4:0]);
    end
    send(16'h7FFF, 16'h0001, 1'b0, 4'b0010, 16'h8000, 5'b00011);
    send(16'h8000, 16'h0001, 1'b0, 4'b0110, 16'h7FFF, 5'b11001);
    flush();
    chk_state("mix");
    while (q.size() != 0) pop_chk("mix");

    do_reset();
    for (int i = 0; i < 4; i++) send(16'(i), 16'h0001, 1'b0, 4'b0010, 16'h0000, 5'b00000);
    flush();
    chk_state("fill");
    head = q.pop_front();
    send(16'h0010, 16'h0001, 1'b0, 4'b0010, 16'h0000, 5'b00000);
    chk("full_pp.head", log_data, head);
    log_ready = 1'b1;
    @(posedge clk);
    #1 log_ready = 1'b0;
    flush();
    chk_state("full_pp");
    for (int i = 0; i < 2; i++) send(16'h0020 + 16'(i), 16'h0001, 1'b0, 4'b0010, 16'h0000, 5'b00000);
    flush();
    chk_state("ovf");
    for (int i = 0; i < 4; i++) pop_chk("ovf");
    chk("ovf.drained", log_valid, 1'b0);

    do_reset();
    send(16'h0001, 16'h0001, 1'b0, 4'b0010, 16'h0005, 5'b00100);
    send(16'h0001, 16'h0001, 1'b0, 4'b0010, 16'h0002, 5'b00100);
    chk("halt.in_ready2", in_ready2, 1'b0);
    flush();
    chk("halt.txn2", txn_count2, 16'd2);
    chk("halt.err_count2", err_count2, 16'd1);
    send(16'h0002, 16'h0002, 1'b0, 4'b0010, 16'h0004, 5'b00100);
    flush();
    chk("halt.txn2_held", txn_count2, 16'd2);
    chk("halt.in_ready2_held", in_ready2, 1'b0);
    chk_state("halt_main");

    send(16'h0001, 16'h0001, 1'b0, 4'b0010, 16'h0009, 5'b00100);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    flush();
    chk("midrst.in_ready", in_ready, 1'b1);
    chk("midrst.in_ready2", in_ready2, 1'b1);
    chk_state("midrst");

    send(16'h1234, 16'h5678, 1'b1, 4'b1111, 16'hDEAD, 5'b11111);
    flush();
    chk("unsup.txn_one", txn_count, 16'd1);
    chk_state("unsup");

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
